// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte-stream requesters, granting whole
// messages round-robin and revoking a grant whose owner goes quiet for too long.
module uart_tx_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              RsTx,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [1:0]        grant_id,
  output logic              busy,
  output logic              abort_pulse
);
  // state | meaning
  // IDLE  | no owner; arbitrate among req_valid starting at rr_ptr
  // OWN   | grant_id owns the transmitter; its bytes pass through tx register
  // DRAIN | message ended or revoked; wait for the held byte to leave, then release
  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t          state;
  logic [1:0]      rr_ptr;
  logic [1:0]      win_id;
  logic [1:0]      next_ptr;
  logic            any_req;
  logic [7:0]      idle_cnt;
  logic [7:0]      idle_inc;
  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] rot;
  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            slot_free;
  logic            accept;
  logic            tx_fire;
  logic            timeout_hit;
  int              idx;

  assign own_oh      = NREQ'(1) << grant_id;
  assign own_valid   = |(req_valid & own_oh);
  assign own_last    = |(req_last & own_oh);
  assign own_data    = 8'(req_data >> {grant_id, 3'b000});
  assign slot_free   = !tx_valid || tx_ready;
  assign accept      = (state == OWN) && own_valid && slot_free;
  assign tx_fire     = tx_valid && tx_ready;
  assign req_ready   = (state == OWN && slot_free) ? own_oh : '0;
  assign idle_inc    = (idle_cnt == 8'hFF) ? 8'hFF : idle_cnt + 8'd1;
  assign timeout_hit = (state == OWN) && !own_valid && (idle_inc >= TIMEOUT_CNT);
  assign next_ptr    = (grant_id == 2'(NREQ-1)) ? 2'd0 : grant_id + 2'd1;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    any_req = 1'b0;
    win_id  = 2'd0;
    idx     = 0;
    rot     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      rot = req_valid >> idx;
      if (rot[0]) begin
        any_req = 1'b1;
        win_id  = 2'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge RsTx) begin
    if (!RsTx) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      grant_id    <= 2'd0;
      busy        <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      abort_pulse <= 1'b0;
      idle_cnt    <= 8'd0;
    end else begin
      abort_pulse <= 1'b0;
      if (accept) begin
        tx_valid <= 1'b1;
        tx_data  <= own_data;
      end else if (tx_fire) begin
        tx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= win_id;
            busy     <= 1'b1;
            idle_cnt <= 8'd0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (accept) begin
            idle_cnt <= 8'd0;
            if (own_last) state <= DRAIN;
          end else if (timeout_hit) begin
            idle_cnt    <= idle_inc;
            abort_pulse <= 1'b1;
            state       <= DRAIN;
          end else if (!own_valid) begin
            idle_cnt <= idle_inc;
          end
        end
        DRAIN: begin
          if (!tx_valid || tx_fire) begin
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, logs of transmitted
// bytes and grant order, compared against hand-derived expectations.
module tb_uart_tx_arbiter;
  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              RsTx = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b0;
  logic [1:0]        grant_id;
  logic              busy;
  logic              abort_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc0_cyc = 0;
  int abort_cyc = 0;
  int abort_cnt = 0;
  logic busy_q = 1'b0;

  logic [8:0] rq [NREQ][$];
  logic [7:0] tx_log[$];
  logic [7:0] exp_b[$];
  logic [1:0] grant_log[$];
  logic [1:0] exp_g[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(10)) dut (
    .clk(clk), .RsTx(RsTx),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .abort_pulse(abort_pulse)
  );

  // Requesters present the head of their queue and hold it until accepted.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = rq[i][0][8];
        req_data[8*i +: 8] = rq[i][0][7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        void'(rq[i].pop_front());
        if (i == 0) acc0_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (busy && !busy_q) grant_log.push_back(grant_id);
    busy_q = busy;
    if (abort_pulse) begin
      abort_cnt = abort_cnt + 1;
      abort_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_len"}, tx_log.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF, 32'(exp_b[i]));
  endtask

  task automatic chk_grants(input string tag);
    chk({tag, "_len"}, grant_log.size(), exp_g.size());
    for (int i = 0; i < exp_g.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp_g[i]));
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int t = 0;
    while (tx_log.size() < n && t < budget) begin
      step(1);
      t++;
    end
    chk(tag, tx_log.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (busy && t < budget) begin
      step(1);
      t++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    tx_log.delete();
    grant_log.delete();
    abort_cnt = 0;
  endtask

  task automatic do_reset();
    RsTx = 1'b0;
    clear_all();
    step(2);
    RsTx = 1'b1;
    step(1);
  endtask

  initial begin
    int t;
    RsTx = 1'b0;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_abort", abort_pulse, 0);
    chk("rst_grant_id", grant_id, 0);
    RsTx = 1'b1;
    step(1);

    // "Hi" from requester 1, cycle by cycle.
    tx_ready = 1'b1;
    rq[1].push_back({1'b0, 8'h48});
    rq[1].push_back({1'b1, 8'h69});
    step(2);
    chk("hi_busy", busy, 1);
    chk("hi_grant", grant_id, 1);
    chk("hi_tx_valid0", tx_valid, 0);
    chk("hi_ready_own", req_ready, 3'b010);
    step(1);
    chk("hi_tx_valid1", tx_valid, 1);
    chk("hi_data0", tx_data, 8'h48);
    step(1);
    chk("hi_data1", tx_data, 8'h69);
    chk("hi_ready_drain", req_ready, 3'b000);
    chk("hi_busy_drain", busy, 1);
    step(1);
    chk("hi_busy_fall", busy, 0);
    chk("hi_tx_valid_end", tx_valid, 0);
    // rr_ptr should now be 2, so requester 2 beats requester 0.
    rq[0].push_back({1'b1, 8'hA0});
    rq[2].push_back({1'b1, 8'hA2});
    wait_bytes("hi_rr_wait", 4, 40);
    exp_b = {8'h48, 8'h69, 8'hA2, 8'hA0};
    chk_bytes("hi_bytes");
    exp_g = {2'd1, 2'd2, 2'd0};
    chk_grants("hi_grants");
    wait_idle("hi_idle", 20);

    // Requesters 0 and 2 contend from reset: no interleaving.
    do_reset();
    tx_ready = 1'b1;
    rq[0].push_back({1'b0, 8'h10});
    rq[0].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b0, 8'h20});
    rq[2].push_back({1'b1, 8'h21});
    wait_bytes("two_wait", 4, 60);
    exp_b = {8'h10, 8'h11, 8'h20, 8'h21};
    chk_bytes("two_bytes");
    exp_g = {2'd0, 2'd2};
    chk_grants("two_grants");
    wait_idle("two_idle", 20);

    // Transmitter back-pressure for 20 cycles.
    do_reset();
    tx_ready = 1'b0;
    rq[1].push_back({1'b0, 8'h55});
    rq[1].push_back({1'b1, 8'h56});
    step(3);
    chk("bp_tx_valid", tx_valid, 1);
    chk("bp_data", tx_data, 8'h55);
    t = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tx_data !== 8'h55 || req_ready !== 3'b000 || tx_valid !== 1'b1) t++;
    end
    chk("bp_hold_bad_cycles", t, 0);
    tx_ready = 1'b1;
    wait_bytes("bp_wait", 2, 20);
    exp_b = {8'h55, 8'h56};
    chk_bytes("bp_bytes");
    wait_idle("bp_idle", 20);

    // Short gap keeps the grant; long gap revokes it after TIMEOUT=10 idle cycles.
    do_reset();
    tx_ready = 1'b1;
    rq[0].push_back({1'b0, 8'h30});
    rq[1].push_back({1'b1, 8'h40});
    step(6);
    rq[0].push_back({1'b0, 8'h31});
    t = 0;
    while (abort_cnt == 0 && t < 40) begin
      step(1);
      t++;
    end
    step(2);
    chk("to_abort_cnt", abort_cnt, 1);
    chk("to_abort_delay", abort_cyc - acc0_cyc, 10);
    wait_bytes("to_wait", 3, 40);
    exp_b = {8'h30, 8'h31, 8'h40};
    chk_bytes("to_bytes");
    exp_g = {2'd0, 2'd1};
    chk_grants("to_grants");
    wait_idle("to_idle", 20);

    // Asynchronous reset mid-message (rr_ptr is 2 here).
    clear_all();
    tx_ready = 1'b0;
    rq[2].push_back({1'b0, 8'h77});
    rq[2].push_back({1'b1, 8'h78});
    step(3);
    chk("ar_tx_valid_pre", tx_valid, 1);
    chk("ar_grant_pre", grant_id, 2);
    RsTx = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_tx_valid", tx_valid, 0);
    chk("ar_tx_data", tx_data, 8'h00);
    chk("ar_req_ready", req_ready, 0);
    chk("ar_abort", abort_pulse, 0);
    chk("ar_grant_id", grant_id, 0);
    clear_all();
    rq[0].push_back({1'b1, 8'hE0});
    rq[2].push_back({1'b1, 8'hE2});
    step(2);
    RsTx = 1'b1;
    tx_ready = 1'b1;
    wait_bytes("ar_wait", 2, 40);
    exp_b = {8'hE0, 8'hE2};
    chk_bytes("ar_bytes");
    exp_g = {2'd0, 2'd2};
    chk_grants("ar_grants");
    wait_idle("ar_idle", 20);

    // Three requesters always valid: fair rotation with wrap.
    do_reset();
    tx_ready = 1'b1;
    rq[0].push_back({1'b1, 8'hB0});
    rq[0].push_back({1'b1, 8'hB3});
    rq[1].push_back({1'b1, 8'hB1});
    rq[1].push_back({1'b1, 8'hB4});
    rq[2].push_back({1'b1, 8'hB2});
    rq[2].push_back({1'b1, 8'hB5});
    wait_bytes("rr_wait", 6, 100);
    exp_b = {8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    chk_bytes("rr_bytes");
    exp_g = {2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    chk_grants("rr_grants");
    wait_idle("rr_idle", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning number of requesters (2..4).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning idle cycles allowed mid-message before the grant is revoked.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RsTx  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester byte valid.
REQ-006 The block SHALL have port req_data  input  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 The block SHALL have port req_last  input  NREQ  marks the final byte of requester i's message.
REQ-008 The block SHALL have port req_ready  output  NREQ  byte accepted from requester i when req_valid[i]&req_ready[i].
REQ-009 The block SHALL have port tx_valid  output  1  byte valid toward the shared UART transmitter.
REQ-010 The block SHALL have port tx_data  output  8  byte toward the transmitter.
REQ-011 The block SHALL have port tx_ready  input  1  transmitter can accept; transfer when tx_valid&tx_ready.
REQ-012 The block SHALL have port grant_id  output  2  index of the current owner; valid only while busy.
REQ-013 The block SHALL have port busy  output  1  a requester holds the grant.
REQ-014 The block SHALL have port abort_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 The FSM SHALL have states IDLE, OWN and DRAIN.
REQ-016 IDLE: if any req_valid is high, the block SHALL pick the winner round-robin starting at pointer rr_ptr, load grant_id, set busy and enter OWN on the next edge; no byte is accepted in that arbitration cycle.
REQ-017 OWN: req_ready[grant_id] SHALL equal (!tx_valid | tx_ready); all other req_ready bits SHALL be 0.
REQ-018 An accepted byte SHALL be registered into tx_data/tx_valid at the same edge (single-entry output register; 1-cycle latency requester to tx_valid).
REQ-019 tx_valid SHALL stay high and tx_data stable until tx_valid&tx_ready; tx_valid clears on that edge unless a new byte is accepted simultaneously, in which case it stays high with the new data.
REQ-020 Acceptance of a byte with req_last[grant_id]=1 SHALL move OWN->DRAIN.
REQ-021 DRAIN: req_ready SHALL be all 0; when tx_valid is 0, or tx_valid&tx_ready occurs, the block SHALL clear busy, set rr_ptr=(grant_id+1) mod NREQ and return to IDLE.
REQ-022 In OWN, an 8-bit saturating idle counter SHALL increment each cycle req_valid[grant_id] is 0 and clear on any accepted byte.
REQ-023 When the idle counter reaches TIMEOUT, the block SHALL pulse abort_pulse for one cycle and enter DRAIN; rr_ptr advances as in REQ-021.
REQ-024 The message of a requester that deasserts req_valid for fewer than TIMEOUT cycles SHALL keep the grant (no interleaving of messages).
REQ-025 Requests arriving in IDLE, OWN or DRAIN SHALL be held by the requester; the block SHALL not latch requests.
REQ-026 rr_ptr wrap: pointer NREQ-1 SHALL advance to 0.

Reset
REQ-027 With RsTx low, the block SHALL force state=IDLE, rr_ptr=0, grant_id=0, busy=0, tx_valid=0, tx_data=8'h00, req_ready=0, abort_pulse=0 and the idle counter=0.
REQ-028 RsTx assertion mid-message SHALL discard any pending tx byte; after release, arbitration restarts from requester 0.

Verification
REQ-029 Single requester 1 sends "Hi" (0x48, 0x69 last) with tx_ready=1 -> tx_data 0x48 then 0x69 on consecutive cycles, busy falls after the 0x69 transfer, and rr_ptr becomes 2.
REQ-030 Requesters 0 and 2 both valid from reset, each sending 2 bytes -> all of 0's bytes are transmitted before any of 2's, then 2 follows, with no interleaving.
REQ-031 tx_ready held low for 20 cycles with byte 0x55 pending -> tx_data stays 0x55, req_ready stays 0, and the byte transfers once when tx_ready rises.
REQ-032 Owner sends 1 non-last byte then drops valid, with TIMEOUT=10 -> abort_pulse occurs 10 cycles later, and the next requester is granted.
REQ-033 RsTx driven low while tx_valid=1 in OWN -> all outputs take their REQ-027 values asynchronously, and the next grant after release goes to requester 0.
REQ-034 All three requesters remain continuously valid across 6 single-byte messages -> grant order is 0,1,2,0,1,2.
